seq_mult_hs: RTL and testbench
==============================

// Module: seq_mult_hs
// PURPOSE
//   Parametrised sequential shift-and-add multiplier. WIDTH x WIDTH -> 2*WIDTH.
//   Per-operation signed/unsigned mode, valid/ready handshakes on both sides,
//   and early termination once the remaining multiplier bits are zero.
//   Sits in the processor datapath as the multi-cycle MUL unit between operand
//   issue and writeback.
// PARAMETERS
//   WIDTH      8   operand width in bits; must be >= 2
//   SIGNED_EN  1   1: the is_signed port is honoured; 0: is_signed is ignored (unsigned only)
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-high reset
//   in_valid   in   1        operands a, b, is_signed are valid
//   in_ready   out  1        block can accept operands (= state IDLE and not reset)
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   is_signed  in   1        1: a and b are two's complement
//   out_valid  out  1        product is valid
//   out_ready  in   1        consumer accepts the product
//   product    out  2*WIDTH  result; registered
//   busy       out  1        high in BUSY and DONE
// BEHAVIOUR
//   Reset (async): state=IDLE, product=0, out_valid=0, busy=0.
//     Internal acc/mcand/mult/neg are cleared.
//     Reset asserted mid-operation aborts the operation; no out_valid is produced.
//   States
//   - IDLE: in_ready=1. When in_valid & in_ready on a clock edge, capture the operands:
//     - sgn = is_signed & SIGNED_EN
//     - mcand = |a| zero-extended to 2*WIDTH
//     - mult = |b| (WIDTH bits unsigned)
//     - neg = sgn & (a[MSB] ^ b[MSB])
//     - acc = 0; go to BUSY.
//     - |x| is x when sgn=0 or x[MSB]=0, otherwise -x.
//       The most negative value maps to 2^(WIDTH-1); this is exact in WIDTH unsigned bits.
//   - BUSY: one multiplier bit per cycle.
//     - If mult==0: product <= neg ? -acc : acc (2*WIDTH, mod 2^(2*WIDTH)); go to DONE.
//     - Else: if mult[0], acc <= acc + mcand; mcand <= mcand<<1; mult <= mult>>1.
//   - DONE: out_valid=1 and product held stable.
//     - When out_ready=1 on an edge: out_valid <= 0; go to IDLE.
//     - out_ready held low stalls in DONE indefinitely.
//   Latency (accept edge -> out_valid high) = k+2 cycles, where k = index of the
//     highest set bit of the mult value captured at accept.
//     - mult==0: 1 cycle.
//     - Worst case: WIDTH+1 cycles.
//   Throughput: earliest next accept is the cycle after the output handshake,
//     because in_ready=0 in DONE.
//   in_valid while not IDLE is ignored; the operands are not captured.
//   product keeps its last value after the handshake until the next result is written.
//   No overflow is possible: the magnitude is <= 2^(2*WIDTH-2) signed, or < 2^(2*WIDTH) unsigned.
// TESTING (WIDTH=8)
//   1. Unsigned 255 x 255: out_valid after 9 cycles; product=16'hFE01.
//   2. Signed -128 x -128: product=16'h4000.
//      Signed -3 x 5: product=16'hFFF1; latency 4 cycles.
//   3. Early termination, a=200, b=0: out_valid 1 cycle after accept; product=0.
//      b=1: 2 cycles; product=200.
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//      -> product stable, in_ready=0, and a new in_valid is ignored.
//      Release -> IDLE; the next op is accepted.
//   5. Reset mid-operation (3 cycles into BUSY): out_valid=0, product=0, in_ready=1
//      after reset deasserts. The next op (7 x 6) returns 42.
//   6. SIGNED_EN=0 with is_signed=1, a=8'hFF, b=8'h02: product=16'h01FE (unsigned).

Source files
------------

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Operands are reduced to magnitudes at accept time, and the sign is
// re-applied when the result is written. The loop walks the multiplier from
// the LSB and stops as soon as the remaining multiplier bits are all zero.
module seq_mult_hs #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mult;
  logic               neg;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;

  // Magnitudes of the incoming operands. The most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  assign sgn   = is_signed & SIGNED_EN;
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)       state_nx = BUSY;
      BUSY:    if (mult == '0)     state_nx = DONE;
      DONE:    if (out_ready)      state_nx = IDLE;
      default:                     state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Datapath: capture on accept, one multiplier bit per BUSY cycle, and
  // write the signed-corrected result when the multiplier is exhausted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mult    <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mult  <= b_mag;
            neg   <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        BUSY: begin
          if (mult == '0) begin
            product <= neg ? -acc : acc;
          end else begin
            if (mult[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mult  <= mult >> 1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed bench for seq_mult_hs at WIDTH=8: a vector table for the main
// function plus hand-written sequences for backpressure, mid-op reset and
// the SIGNED_EN=0 build.
module tb_seq_mult_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] product;

  logic        in_valid2, in_ready2, out_valid2, busy2;
  logic        out_ready2;
  logic [15:0] product2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .product(product), .busy(busy)
  );

  seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid2),
    .out_ready(out_ready2), .product(product2), .busy(busy2)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sg;
    logic [15:0] p;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op on the signed-capable DUT, measure latency, check the
  // result and complete the output handshake.
  task automatic run_op(input string name, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isg, input logic [15:0] exp_p, input int exp_lat);
    int lat;
    a = ia; b = ib; is_signed = isg; in_valid = 1'b1;
    chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " product"}, {16'd0, product}, {16'd0, exp_p});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " post out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, " post in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int n;
    logic stray;
    vt[0]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 9};
    vt[1]  = '{8'h80, 8'h80, 1'b1, 16'h4000, 9};
    vt[2]  = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, 4};
    vt[3]  = '{8'd200, 8'h00, 1'b0, 16'h0000, 1};
    vt[4]  = '{8'd200, 8'h01, 1'b0, 16'h00C8, 2};
    vt[5]  = '{8'd7,  8'd6,  1'b0, 16'h002A, 4};
    vt[6]  = '{8'h05, 8'hFD, 1'b1, 16'hFFF1, 3};
    vt[7]  = '{8'h7F, 8'h80, 1'b1, 16'hC080, 9};
    vt[8]  = '{8'h80, 8'h80, 1'b0, 16'h4000, 9};
    vt[9]  = '{8'hFF, 8'hFF, 1'b1, 16'h0001, 2};
    vt[10] = '{8'h00, 8'hFB, 1'b1, 16'h0000, 4};
    vt[11] = '{8'hFF, 8'h02, 1'b0, 16'h01FE, 3};

    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b0;
    out_ready2 = 1'b1; a = '0; b = '0; is_signed = 1'b0;
    tick(); tick();
    chk("reset product",   {16'd0, product}, 32'd0);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset busy",      {31'd0, busy}, 32'd0);
    chk("reset in_ready",  {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sg, vt[i].p, vt[i].lat);

    // Backpressure: 13 x 11 = 143, held in DONE for 10 cycles with a
    // competing in_valid that must be ignored.
    a = 8'd13; b = 8'd11; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    chk("bp latency", n, 5);
    for (int i = 0; i < 10; i++) begin
      a = 8'(i + 1); b = 8'hAA; in_valid = 1'b1;
      tick();
      chk($sformatf("bp product c%0d", i), {16'd0, product}, 32'h008F);
      chk($sformatf("bp in_ready c%0d", i), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp out_valid c%0d", i), {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp release out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp release in_ready",  {31'd0, in_ready}, 32'd1);
    chk("bp held product",      {16'd0, product}, 32'h008F);
    run_op("bp next", 8'd3, 8'd3, 1'b0, 16'h0009, 3);

    // Reset three cycles into a long op.
    a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("midrst busy before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst product",   {16'd0, product}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst in_ready", {31'd0, in_ready}, 32'd1);
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      stray |= out_valid;
    end
    chk("midrst no stray out_valid", {31'd0, stray}, 32'd0);
    chk("midrst product after", {16'd0, product}, 32'd0);
    run_op("midrst next", 8'd7, 8'd6, 1'b0, 16'h002A, 4);

    // Unsigned-only build ignores is_signed.
    a = 8'hFF; b = 8'h02; is_signed = 1'b1; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!out_valid2 && n < 40);
    chk("unsig latency", n, 3);
    chk("unsig product", {16'd0, product2}, 32'h01FE);
    tick();
    chk("unsig consumed", {31'd0, out_valid2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
